wb_queue: RTL and testbench
===========================

# wb_queue

Write-back queue between the MEM/EXE result producers and the register file's single write port. It accepts up to two results per cycle: a load result from MEM and an ALU result from EXE. It holds them in program order in a small FIFO and drains one per cycle into the register file. It also provides read-after-write forwarding for pending entries on the two register-read indices.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 4
- DATA_W, 32, result width
- ADDR_W, 4, register index width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- mem_wb_en  in  1  load result valid this cycle
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- alu_wb_en  in  1  ALU result valid this cycle
- alu_dest  in  ADDR_W  ALU destination register
- alu_result  in  DATA_W  ALU data
- src1, src2  in  ADDR_W  register-read indices, the same values the register file sees
- rf_we  out  1  register file write enable
- rf_dest  out  ADDR_W  register file write index
- rf_data  out  DATA_W  register file write data
- fwd1_hit, fwd2_hit  out  1  a pending entry matches src1 / src2
- fwd1_data, fwd2_data  out  DATA_W  forwarded value
- stall  out  1  upstream must not push this cycle
- count  out  log2(DEPTH)+1  occupied entries
- ovf  out  1  sticky overflow flag

## Operation
- Circular FIFO with wr_ptr, rd_ptr and count. Entries hold {dest, data}.
- Push order within a cycle: the MEM entry goes first (older instruction), then the ALU entry. Each entry is pushed only if its enable is high.
- Head drain: rf_we = (count != 0), with rf_dest and rf_data taken from the head entry. The pop happens on the same posedge that the register file writes.
- Simultaneous pop and pushes on one edge: count_next = count + mem_wb_en + alu_wb_en − pop. Pointers wrap modulo DEPTH.
- stall = (count ≥ DEPTH−1). It is combinational from registered count, which guarantees room for two pushes next edge.
- Overflow: if a push would exceed DEPTH, the excess push is dropped and ovf sets. ovf stays set until rst.
- Forwarding: for each src, search valid entries from youngest to oldest. The first dest match gives hit=1 and that entry's data. The head entry being written this cycle still counts as a match. Same-cycle incoming pushes are not searched. No match gives hit=0 and data=0.
- Register index 15 receives no special handling.

## Timing
- Reset values: count=0, pointers=0, rf_we=0, rf_dest=0, rf_data=0, fwd*_hit=0, fwd*_data=0, stall=0, ovf=0. rf_we drops immediately on rst assertion.
- Reset mid-operation discards all pending writes; none reach the register file.
- Latency: an entry pushed at edge N is at the head after N. With an empty queue it is written at edge N+1. Each older entry adds one cycle.
- Throughput: one register file write per cycle. Two pushes per cycle are sustained only while count < DEPTH−1.
- All outputs except the FIFO state are combinational from registered state and src1/src2. No path exists from mem_/alu_ inputs to outputs.

## Configuration
- WB_QUEUE_FWD_EN defined: forwarding logic as above.
- Undefined: fwd*_hit and fwd*_data are tied to 0. In addition, stall is also asserted whenever src1 or src2 matches any pending dest (RAW interlock), so the pipeline waits for the drain.

## Test plan
- Reset, then a single ALU push of dest=3, data=0x11: rf_we=1, rf_dest=3, rf_data=0x11 in the next cycle, and count returns to 0 after that edge.
- Same-cycle MEM push of dest=2, data=0xAA and ALU push of dest=5, data=0xBB: writes occur in order R2 then R5 on consecutive cycles. count reads 2 → 1 → 0.
- Two pending writes to R7 (0x1 older, 0x2 younger) with src1=7: with FWD_EN, fwd1_hit=1 and fwd1_data=0x2. Without FWD_EN, stall=1 until count=0.
- Dual pushes every cycle with DEPTH=4: stall asserts at count=3. A forced extra push while full sets ovf=1, and ovf stays set.
- Assert rst with count=3: rf_we falls without a clock edge, count=0, and no further writes appear after rst is released.

Source files
------------

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
//
// Write-back queue between the MEM/EXE result producers and the register
// file's single write port. Up to two results are accepted per cycle: the
// MEM load result first (the older instruction), then the EXE ALU result.
// They are held in program order in a circular FIFO, and one entry per
// cycle is drained into the register file.
//
// Build option:
//   WB_QUEUE_FWD_EN defined   - read-after-write forwarding from pending
//                               entries onto fwd1_* / fwd2_*.
//   WB_QUEUE_FWD_EN undefined - fwd*_hit / fwd*_data tied to 0, and stall
//                               also asserts while src1/src2 matches any
//                               pending destination (RAW interlock).
//
// Ports:
//   clk, rst            clock (posedge), asynchronous active-high reset
//   mem_wb_en/dest/data load result push (older of the pair)
//   alu_wb_en/dest/...  ALU result push (younger of the pair)
//   src1, src2          register-read indices used for the forwarding search
//   rf_we/dest/data     register file write port, driven from the FIFO head
//   fwd{1,2}_hit/data   forwarding result for src1/src2
//   stall               upstream must not push this cycle
//   count               occupied entries
//   ovf                 sticky overflow flag (a push was dropped)
// -----------------------------------------------------------------------------
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_wb_en,
  input  logic [ADDR_W-1:0]      mem_dest,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   alu_wb_en,
  input  logic [ADDR_W-1:0]      alu_dest,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [ADDR_W-1:0]      src1,
  input  logic [ADDR_W-1:0]      src2,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_dest,
  output logic [DATA_W-1:0]      rf_data,
  output logic                   fwd1_hit,
  output logic [DATA_W-1:0]      fwd1_data,
  output logic                   fwd2_hit,
  output logic [DATA_W-1:0]      fwd2_data,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  // At DEPTH-1 or above there may not be room for two pushes next edge.
  localparam logic [CW-1:0] STALL_LVL_C = CW'(DEPTH - 1);

  // FIFO storage and control state
  logic [ADDR_W-1:0] dest_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;

  // Next-state helpers
  logic              pop_s;
  logic [CW-1:0]     level_s;
  logic [CW-1:0]     level2_s;
  logic [CW-1:0]     count_nxt_s;
  logic              mem_acc_s;
  logic              alu_acc_s;
  logic              ovf_set_s;
  logic [PW-1:0]     alu_ptr_s;
  logic [PW-1:0]     wr_ptr_nxt_s;
  logic [PW-1:0]     rd_ptr_nxt_s;

  // Logical-to-physical slot map used by the forwarding / interlock search
  logic [PW-1:0]     slot_s     [DEPTH];
  logic              slot_vld_s [DEPTH];

  // Push/pop bookkeeping: the head pops first, then MEM, then ALU claim space
  always_comb begin
    pop_s        = (count_r != {CW{1'b0}});
    // The head slot frees on the same edge, so a full queue still takes one push.
    level_s      = count_r - CW'(pop_s);
    mem_acc_s    = mem_wb_en && (level_s < DEPTH_C);
    level2_s     = level_s + CW'(mem_acc_s);
    alu_acc_s    = alu_wb_en && (level2_s < DEPTH_C);
    count_nxt_s  = level2_s + CW'(alu_acc_s);
    ovf_set_s    = (mem_wb_en && !mem_acc_s) || (alu_wb_en && !alu_acc_s);
    // The ALU entry lands behind the MEM entry only if the MEM entry was taken.
    alu_ptr_s    = wr_ptr_r + PW'(mem_acc_s);
    wr_ptr_nxt_s = alu_ptr_s + PW'(alu_acc_s);
    rd_ptr_nxt_s = rd_ptr_r + PW'(pop_s);
  end

  // Control state: pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ovf_r    <= ovf_r | ovf_set_s;
    end
  end

  // Entry storage: accepted pushes are written in program order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (mem_acc_s) begin
        dest_mem_r[wr_ptr_r] <= mem_dest;
        data_mem_r[wr_ptr_r] <= mem_data;
      end
      if (alu_acc_s) begin
        dest_mem_r[alu_ptr_s] <= alu_dest;
        data_mem_r[alu_ptr_s] <= alu_result;
      end
    end
  end

  // Register file write port driven straight from the head entry
  always_comb begin
    rf_we = pop_s;
    if (pop_s) begin
      rf_dest = dest_mem_r[rd_ptr_r];
      rf_data = data_mem_r[rd_ptr_r];
    end else begin
      rf_dest = {ADDR_W{1'b0}};
      rf_data = {DATA_W{1'b0}};
    end
  end

  // Slot i in program order (0 = oldest) and whether it holds a pending entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_s[i]     = rd_ptr_r + PW'(i);
      slot_vld_s[i] = (CW'(i) < count_r);
    end
  end

`ifdef WB_QUEUE_FWD_EN

  // Forwarding search; scanning oldest to youngest lets the youngest match win
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = {DATA_W{1'b0}};
    fwd2_hit  = 1'b0;
    fwd2_data = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld_s[i] && (dest_mem_r[slot_s[i]] == src1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_mem_r[slot_s[i]];
      end else begin
        fwd1_hit  = fwd1_hit;
        fwd1_data = fwd1_data;
      end
      if (slot_vld_s[i] && (dest_mem_r[slot_s[i]] == src2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_mem_r[slot_s[i]];
      end else begin
        fwd2_hit  = fwd2_hit;
        fwd2_data = fwd2_data;
      end
    end
  end

  // Back-pressure purely on occupancy
  always_comb begin
    stall = (count_r >= STALL_LVL_C);
  end

`else

  logic raw_s;

  // No forwarding: hold the pipeline while any pending entry targets src1/src2
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = {DATA_W{1'b0}};
    fwd2_hit  = 1'b0;
    fwd2_data = {DATA_W{1'b0}};
    raw_s     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld_s[i] &&
          ((dest_mem_r[slot_s[i]] == src1) || (dest_mem_r[slot_s[i]] == src2))) begin
        raw_s = 1'b1;
      end else begin
        raw_s = raw_s;
      end
    end
    stall = (count_r >= STALL_LVL_C) || raw_s;
  end

`endif

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue
//
// Directed, table-driven bench for wb_queue (DEPTH=4, DATA_W=32, ADDR_W=4).
// Each table row gives the inputs applied for the next clock edge together
// with the outputs expected from the current registered state. Inputs are
// driven on the falling edge and outputs sampled 1 time unit later. A
// hand-written sequence covers reset asserted in the middle of operation.
// Expected forwarding/stall values follow WB_QUEUE_FWD_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

`ifdef WB_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_wb_en;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              alu_wb_en;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_data;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic              stall;
  logic [2:0]        count;
  logic              ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wb_en  (mem_wb_en),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .alu_wb_en  (alu_wb_en),
    .alu_dest   (alu_dest),
    .alu_result (alu_result),
    .src1       (src1),
    .src2       (src2),
    .rf_we      (rf_we),
    .rf_dest    (rf_dest),
    .rf_data    (rf_data),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data),
    .stall      (stall),
    .count      (count),
    .ovf        (ovf)
  );

  typedef struct {
    logic        me;   logic [3:0] md; logic [31:0] mdat;
    logic        ae;   logic [3:0] ad; logic [31:0] adat;
    logic [3:0]  s1;   logic [3:0] s2;
    logic        we;   logic [3:0] dest; logic [31:0] data;
    logic [2:0]  cnt;
    logic        stl_fwd;  // stall expected with forwarding
    logic        stl_raw;  // stall expected with the RAW interlock
    logic        ov;
    logic        h1;   logic [31:0] d1;
    logic        h2;   logic [31:0] d2;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(
    input logic me, input logic [3:0] md, input logic [31:0] mdat,
    input logic ae, input logic [3:0] ad, input logic [31:0] adat,
    input logic [3:0] s1, input logic [3:0] s2,
    input logic we, input logic [3:0] dest, input logic [31:0] data,
    input logic [2:0] cnt, input logic stf, input logic str, input logic ov,
    input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
    vec_t v;
    v.me = me; v.md = md; v.mdat = mdat;
    v.ae = ae; v.ad = ad; v.adat = adat;
    v.s1 = s1; v.s2 = s2;
    v.we = we; v.dest = dest; v.data = data; v.cnt = cnt;
    v.stl_fwd = stf; v.stl_raw = str; v.ov = ov;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    return v;
  endfunction

  task automatic chk(input string name, input int step,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic me, input logic [3:0] md, input logic [31:0] mdat,
                       input logic ae, input logic [3:0] ad, input logic [31:0] adat,
                       input logic [3:0] s1, input logic [3:0] s2);
    mem_wb_en  = me;  mem_dest = md;  mem_data   = mdat;
    alu_wb_en  = ae;  alu_dest = ad;  alu_result = adat;
    src1       = s1;  src2     = s2;
  endtask

  initial begin
    //                me  md  mdat   ae  ad  adat   s1  s2   we dst data   cnt sf sr ov  h1 d1   h2 d2
    // single ALU push R3 = 0x11
    vecs[0]  = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    vecs[1]  = mk(0,  0, 'h00,  1,  3, 'h11,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    vecs[2]  = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   1, 3, 'h11,  1,  0, 0, 0,  0, 0,   0, 0);
    vecs[3]  = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    // MEM R2 = 0xAA and ALU R5 = 0xBB in one cycle: R2 drains first
    vecs[4]  = mk(1,  2, 'hAA,  1,  5, 'hBB,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    vecs[5]  = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   1, 2, 'hAA,  2,  0, 0, 0,  0, 0,   0, 0);
    vecs[6]  = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   1, 5, 'hBB,  1,  0, 0, 0,  0, 0,   0, 0);
    vecs[7]  = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    // two pending writes to R7: youngest (0x2) must be forwarded
    vecs[8]  = mk(1,  7, 'h01,  1,  7, 'h02,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    vecs[9]  = mk(0,  0, 'h00,  0,  0, 'h00,  7,  2,   1, 7, 'h01,  2,  0, 1, 0,  1, 'h02, 0, 0);
    vecs[10] = mk(0,  0, 'h00,  0,  0, 'h00,  7,  7,   1, 7, 'h02,  1,  0, 1, 0,  1, 'h02, 1, 'h02);
    vecs[11] = mk(0,  0, 'h00,  0,  0, 'h00,  7,  7,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    // dual pushes every cycle, forced past stall, then one dropped push
    vecs[12] = mk(1,  1, 'h10,  1,  4, 'h20,  0,  0,   0, 0, 'h00,  0,  0, 0, 0,  0, 0,   0, 0);
    vecs[13] = mk(1,  6, 'h30,  1,  8, 'h40,  0,  0,   1, 1, 'h10,  2,  0, 0, 0,  0, 0,   0, 0);
    vecs[14] = mk(1,  9, 'h50,  1, 10, 'h60,  0,  0,   1, 4, 'h20,  3,  1, 1, 0,  0, 0,   0, 0);
    vecs[15] = mk(1, 11, 'h70,  1, 12, 'h80,  0,  0,   1, 6, 'h30,  4,  1, 1, 0,  0, 0,   0, 0);
    // R12 was dropped, so src2=12 must miss; R9 sits mid-queue
    vecs[16] = mk(0,  0, 'h00,  0,  0, 'h00,  9, 12,   1, 8, 'h40,  4,  1, 1, 1,  1, 'h50, 0, 0);
    vecs[17] = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   1, 9, 'h50,  3,  1, 1, 1,  0, 0,   0, 0);
    vecs[18] = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   1,10, 'h60,  2,  0, 0, 1,  0, 0,   0, 0);
    vecs[19] = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   1,11, 'h70,  1,  0, 0, 1,  0, 0,   0, 0);
    vecs[20] = mk(0,  0, 'h00,  0,  0, 'h00,  0,  0,   0, 0, 'h00,  0,  0, 0, 1,  0, 0,   0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_rf_we", -1, 32'(rf_we), 32'd0);
    chk("reset_count", -1, 32'(count), 32'd0);
    chk("reset_stall", -1, 32'(stall), 32'd0);
    chk("reset_ovf",   -1, 32'(ovf),   32'd0);
    chk("reset_rf_dest", -1, 32'(rf_dest), 32'd0);
    chk("reset_rf_data", -1, rf_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].me, vecs[i].md, vecs[i].mdat, vecs[i].ae, vecs[i].ad, vecs[i].adat,
            vecs[i].s1, vecs[i].s2);
      #1;
      chk("rf_we",     i, 32'(rf_we),   32'(vecs[i].we));
      chk("rf_dest",   i, 32'(rf_dest), 32'(vecs[i].dest));
      chk("rf_data",   i, rf_data,      vecs[i].data);
      chk("count",     i, 32'(count),   32'(vecs[i].cnt));
      chk("stall",     i, 32'(stall),   32'(FWD ? vecs[i].stl_fwd : vecs[i].stl_raw));
      chk("ovf",       i, 32'(ovf),     32'(vecs[i].ov));
      chk("fwd1_hit",  i, 32'(fwd1_hit), 32'(FWD ? vecs[i].h1 : 1'b0));
      chk("fwd1_data", i, fwd1_data,     FWD ? vecs[i].d1 : 32'd0);
      chk("fwd2_hit",  i, 32'(fwd2_hit), 32'(FWD ? vecs[i].h2 : 1'b0));
      chk("fwd2_data", i, fwd2_data,     FWD ? vecs[i].d2 : 32'd0);
      @(negedge clk);
    end

    // Reset asserted between edges with three entries pending
    drive(1, 1, 'hA1, 1, 2, 'hA2, 0, 0);
    @(negedge clk);
    drive(1, 3, 'hA3, 1, 4, 'hA4, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_count", 100, 32'(count), 32'd3);
    chk("pre_rst_we",    100, 32'(rf_we), 32'd1);
    chk("pre_rst_dest",  100, 32'(rf_dest), 32'd2);
    chk("pre_rst_stall", 100, 32'(stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we",    101, 32'(rf_we), 32'd0);
    chk("mid_rst_count", 101, 32'(count), 32'd0);
    chk("mid_rst_ovf",   101, 32'(ovf),   32'd0);
    chk("mid_rst_stall", 101, 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_rst_we",    102 + k, 32'(rf_we), 32'd0);
      chk("post_rst_count", 102 + k, 32'(count), 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
